// File: rtl/hexdump_tx.sv
// hexdump_tx: pops fifo bytes and streams them to uart_tx as lowercase hex text, CR LF per line
module hexdump_tx #(
  parameter int BYTES_PER_LINE = 16,
  parameter int IDLE_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_available,
  input  logic [7:0] read_data,
  output logic       read_strobe,
  input  logic       uart_ready,
  output logic [7:0] uart_data,
  output logic       uart_strobe,
  output logic       busy
);
  localparam int CW = $clog2(BYTES_PER_LINE + 1);
  localparam int IW = IDLE_TIMEOUT > 0 ? $clog2(IDLE_TIMEOUT + 1) : 1;
  typedef enum logic [2:0] {IDLE, HI, LO, SEP, CR, LF} state_t;
  state_t state, state_n;
  logic [CW-1:0] col, col_n;
  logic [IW-1:0] idle_cnt, idle_n;
  logic [7:0] data_q, data_n, uart_data_n;
  logic rd_hold, read_strobe_n, uart_strobe_n, send, pop, expire;
  function automatic logic [7:0] hex(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'd0, n} : 8'h57 + {4'd0, n};
  endfunction
  assign busy = state != IDLE;
  // a live uart_strobe doubles as the holdoff, since uart_ready may lag the load by a cycle
  assign send = uart_ready && !uart_strobe;
  assign pop = state == IDLE && data_available && !rd_hold;
  assign expire = idle_cnt == IW'(IDLE_TIMEOUT - 1);
  always_comb begin
    state_n = state;
    col_n = col;
    idle_n = idle_cnt;
    data_n = data_q;
    uart_data_n = uart_data;
    read_strobe_n = 1'b0;
    uart_strobe_n = 1'b0;
    if (pop) begin
      read_strobe_n = 1'b1;
      data_n = read_data;
      idle_n = '0;
      state_n = HI;
    end else if (state == IDLE) begin
      if (col != '0 && IDLE_TIMEOUT != 0) begin
        idle_n = expire ? '0 : idle_cnt + 1'b1;
        state_n = expire ? CR : IDLE;
      end else
        idle_n = '0;
    end else if (send) begin
      uart_strobe_n = 1'b1;
      uart_data_n = state == HI ? hex(data_q[7:4]) :
                    state == LO ? hex(data_q[3:0]) :
                    state == SEP ? 8'h20 :
                    state == CR ? 8'h0d : 8'h0a;
      col_n = state == LO ? col + 1'b1 : state == LF ? '0 : col;
      state_n = state == HI ? LO :
                state == LO ? (col + 1'b1 == CW'(BYTES_PER_LINE) ? CR : SEP) :
                state == CR ? LF : IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      col <= '0;
      idle_cnt <= '0;
      data_q <= '0;
      uart_data <= '0;
      read_strobe <= 1'b0;
      uart_strobe <= 1'b0;
      rd_hold <= 1'b0;
    end else begin
      state <= state_n;
      col <= col_n;
      idle_cnt <= idle_n;
      data_q <= data_n;
      uart_data <= uart_data_n;
      read_strobe <= read_strobe_n;
      uart_strobe <= uart_strobe_n;
      rd_hold <= read_strobe;
    end
  end
endmodule

// File: tb/tb_hexdump_tx.sv
// tb_hexdump_tx: directed checks of hexdump_tx with a fifo model and a uart byte recorder
module tb_hexdump_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst[2], da[2], rs[2], ur[2], us[2], bz[2];
  logic [7:0] rd[2], ud[2];
  hexdump_tx #(.BYTES_PER_LINE(4), .IDLE_TIMEOUT(100)) dut_a (
    .clk(clk), .reset(rst[0]), .data_available(da[0]), .read_data(rd[0]), .read_strobe(rs[0]),
    .uart_ready(ur[0]), .uart_data(ud[0]), .uart_strobe(us[0]), .busy(bz[0]));
  hexdump_tx #(.BYTES_PER_LINE(16), .IDLE_TIMEOUT(0)) dut_b (
    .clk(clk), .reset(rst[1]), .data_available(da[1]), .read_data(rd[1]), .read_strobe(rs[1]),
    .uart_ready(ur[1]), .uart_data(ud[1]), .uart_strobe(us[1]), .busy(bz[1]));
  logic [7:0] fq[2][$];
  logic [7:0] got[2][$];
  int sc[2][$];
  int pops[2], bad_pop[2], us_b2b[2], rs_b2b[2];
  logic us_p[2], rs_p[2];
  int cyc = 0, total = 0, bad = 0;
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (us[i] === 1'b1) begin
        got[i].push_back(ud[i]);
        sc[i].push_back(cyc);
        if (us_p[i]) us_b2b[i]++;
      end
      if (rs[i] === 1'b1) begin
        pops[i]++;
        if (rs_p[i]) rs_b2b[i]++;
        if (fq[i].size() == 0) bad_pop[i]++;
        else void'(fq[i].pop_front());
      end
      us_p[i] = us[i] === 1'b1;
      rs_p[i] = rs[i] === 1'b1;
      da[i] = fq[i].size() != 0;
      rd[i] = da[i] ? fq[i][0] : 8'h00;
    end
  end
  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  function automatic int first_diff(input int i, input string s);
    int n = got[i].size() > s.len() ? got[i].size() : s.len();
    for (int k = 0; k < n; k++)
      if (k >= got[i].size() || k >= s.len() || got[i][k] != s[k]) return k;
    return -1;
  endfunction
  task automatic clr(input int i);
    got[i].delete();
    sc[i].delete();
    pops[i] = 0;
    bad_pop[i] = 0;
    us_b2b[i] = 0;
    rs_b2b[i] = 0;
  endtask
  task automatic wait_chars(input int i, input int n, input int budget);
    int k = 0;
    while (got[i].size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("chars%0d", i), got[i].size(), n);
  endtask
  initial begin
    string s;
    int k, n;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      ur[i] = 1'b1;
      us_p[i] = 1'b0;
      rs_p[i] = 1'b0;
      clr(i);
    end
    repeat (3) @(negedge clk);
    check("rst_rs", rs[0], 0);
    check("rst_us", us[0], 0);
    check("rst_ud", ud[0], 0);
    check("rst_busy", bz[0], 0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int b = 0; b < 4; b++) fq[0].push_back(8'(b));
    wait_chars(0, 13, 300);
    repeat (300) @(negedge clk);
    check("line4", first_diff(0, "00 01 02 03\r\n"), -1);
    check("pops4", pops[0], 4);
    check("rs_b2b", rs_b2b[0], 0);
    check("us_b2b", us_b2b[0], 0);
    check("idle_busy", bz[0], 0);
    clr(0);
    fq[0].push_back(8'haf);
    wait_chars(0, 5, 400);
    check("af_flush", first_diff(0, "af \r\n"), -1);
    check("flush_gap", sc[0][3] - sc[0][2], 101);
    clr(0);
    for (int b = 1; b <= 4; b++) fq[0].push_back(8'(b));
    wait_chars(0, 13, 400);
    check("col0_after_flush", first_diff(0, "01 02 03 04\r\n"), -1);
    clr(0);
    fq[0].push_back(8'h3c);
    wait_chars(0, 1, 50);
    ur[0] = 1'b0;
    n = got[0].size();
    repeat (50) @(negedge clk);
    check("bp_hold", got[0].size(), n);
    ur[0] = 1'b1;
    wait_chars(0, 5, 400);
    check("bp_stream", first_diff(0, "3c \r\n"), -1);
    check("bp_b2b", us_b2b[0], 0);
    clr(0);
    fq[0].push_back(8'h5a);
    k = 0;
    while (rs[0] !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("pop5a", rs[0], 1);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("mid_rs", rs[0], 0);
    check("mid_us", us[0], 0);
    check("mid_ud", ud[0], 0);
    check("mid_busy", bz[0], 0);
    fq[0].push_back(8'h11);
    wait_chars(0, 5, 400);
    check("after_reset", first_diff(0, "11 \r\n"), -1);
    s = "";
    for (int b = 8'h10; b <= 8'h23; b++)
      s = {s, $sformatf("%02x", b), b == 8'h1f ? "\r\n" : " "};
    for (int b = 8'h10; b <= 8'h23; b++) fq[1].push_back(8'(b));
    wait_chars(1, 61, 2000);
    repeat (100) @(negedge clk);
    check("lines16", first_diff(1, s), -1);
    check("pops20", pops[1], 20);
    check("empty_pop", bad_pop[1], 0);
    check("b_us_b2b", us_b2b[1], 0);
    check("b_rs_b2b", rs_b2b[1], 0);
    rst[1] = 1'b1;
    repeat (2) @(negedge clk);
    rst[1] = 1'b0;
    clr(1);
    fq[1].push_back(8'h7e);
    repeat (10000) @(negedge clk);
    check("no_flush", first_diff(1, "7e "), -1);
    check("b_busy", bz[1], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
